// File: rtl/alu_rs.sv
// Reservation station in front of the integer ALU. Micro-ops wait here until both
// operands arrive by tag, then issue in lowest-index order; the ALU result is rebroadcast.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int IDX_W   = 3,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [3:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic              issue_qj_busy,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              issue_qk_busy,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [TAG_W-1:0]  issue_dest,
  output logic              rs_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              alu_ready,
  output logic [DATA_W-1:0] alu_lv,
  output logic [DATA_W-1:0] alu_rv,
  output logic [3:0]        alu_op,
  input  logic              alu_success,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_value
);

  logic [RS_SIZE-1:0] busy, qj_busy, qk_busy;
  logic [3:0]         op   [RS_SIZE];
  logic [DATA_W-1:0]  vj   [RS_SIZE];
  logic [DATA_W-1:0]  vk   [RS_SIZE];
  logic [TAG_W-1:0]   qj   [RS_SIZE];
  logic [TAG_W-1:0]   qk   [RS_SIZE];
  logic [TAG_W-1:0]   dest [RS_SIZE];
  logic [TAG_W-1:0]   tag_p1;

  logic [RS_SIZE-1:0] ready, j_cdb, j_out, k_cdb, k_out;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic               any_ready, accept, dispatch, complete;
  logic               in_j_cdb, in_j_out, in_k_cdb, in_k_out;

  function automatic logic tag_hit(input logic valid, input logic pend,
                                   input logic [TAG_W-1:0] q, input logic [TAG_W-1:0] tag);
    return valid && pend && (q == tag);
  endfunction

  always_comb begin
    ready    = busy & ~qj_busy & ~qk_busy;
    free_idx = '0;
    sel_idx  = '0;
    j_cdb    = '0;
    j_out    = '0;
    k_cdb    = '0;
    k_out    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      if (ready[i]) sel_idx = IDX_W'(i);
      j_cdb[i] = tag_hit(cdb_valid, qj_busy[i], qj[i], cdb_tag);
      j_out[i] = tag_hit(out_valid, qj_busy[i], qj[i], out_tag);
      k_cdb[i] = tag_hit(cdb_valid, qk_busy[i], qk[i], cdb_tag);
      k_out[i] = tag_hit(out_valid, qk_busy[i], qk[i], out_tag);
    end
  end

  assign rs_full   = &busy;
  assign any_ready = |ready;
  assign accept    = issue_valid && !rs_full;
  assign dispatch  = any_ready && (!alu_ready || alu_success);
  assign complete  = alu_ready && alu_success;

  // The op being written this edge can also catch a same-cycle broadcast.
  assign in_j_cdb = tag_hit(cdb_valid, issue_qj_busy, issue_qj, cdb_tag);
  assign in_j_out = tag_hit(out_valid, issue_qj_busy, issue_qj, out_tag);
  assign in_k_cdb = tag_hit(cdb_valid, issue_qk_busy, issue_qk, cdb_tag);
  assign in_k_out = tag_hit(out_valid, issue_qk_busy, issue_qk, out_tag);

  // Stage p0 -> p1: entry control, ALU operand registers, result broadcast.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      qj_busy   <= '0;
      qk_busy   <= '0;
      alu_ready <= 1'b0;
      alu_lv    <= '0;
      alu_rv    <= '0;
      alu_op    <= '0;
      tag_p1    <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_value <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy      <= '0;
        alu_ready <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        qj_busy <= qj_busy & ~(j_cdb | j_out);
        qk_busy <= qk_busy & ~(k_cdb | k_out);
        if (dispatch) begin
          busy[sel_idx] <= 1'b0;
          alu_ready     <= 1'b1;
          alu_lv        <= vj[sel_idx];
          alu_rv        <= vk[sel_idx];
          alu_op        <= op[sel_idx];
          tag_p1        <= dest[sel_idx];
        end else if (complete) begin
          alu_ready <= 1'b0;
        end
        out_valid <= complete;
        if (complete) begin
          out_tag   <= tag_p1;
          out_value <= alu_result;
        end
        // free_idx is never the dispatched entry, so these writes cannot collide.
        if (accept) begin
          busy[free_idx]    <= 1'b1;
          qj_busy[free_idx] <= issue_qj_busy && !(in_j_cdb || in_j_out);
          qk_busy[free_idx] <= issue_qk_busy && !(in_k_cdb || in_k_out);
        end
      end
    end
  end

  // Entry payload carries no reset; busy qualifies every use of it.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (j_cdb[i])      vj[i] <= cdb_value;
        else if (j_out[i]) vj[i] <= out_value;
        if (k_cdb[i])      vk[i] <= cdb_value;
        else if (k_out[i]) vk[i] <= out_value;
      end
      if (accept) begin
        op[free_idx]   <= issue_op;
        qj[free_idx]   <= issue_qj;
        qk[free_idx]   <= issue_qk;
        dest[free_idx] <= issue_dest;
        vj[free_idx]   <= in_j_cdb ? cdb_value : (in_j_out ? out_value : issue_vj);
        vk[free_idx]   <= in_k_cdb ? cdb_value : (in_k_out ? out_value : issue_vk);
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: the bench plays dispatcher, CDB source and ALU
// (add/sub on opcodes 0/1), and logs every result broadcast for comparison.
module tb_alu_rs;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        issue_valid, issue_qj_busy, issue_qk_busy;
  logic [3:0]  issue_op, issue_qj, issue_qk, issue_dest;
  logic [31:0] issue_vj, issue_vk;
  logic        rs_full;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        alu_ready, alu_success, out_valid;
  logic [31:0] alu_lv, alu_rv, alu_result, out_value;
  logic [3:0]  alu_op, out_tag;
  logic        alu_hold;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [3:0]  q_tag [$];
  logic [31:0] q_val [$];
  int          q_cyc [$];

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj),
    .issue_vk(issue_vk), .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
    .issue_dest(issue_dest), .rs_full(rs_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_ready(alu_ready), .alu_lv(alu_lv), .alu_rv(alu_rv), .alu_op(alu_op),
    .alu_success(alu_success), .alu_result(alu_result),
    .out_valid(out_valid), .out_tag(out_tag), .out_value(out_value)
  );

  always #5 clk = ~clk;

  assign alu_success = !alu_hold;
  assign alu_result  = (alu_op == OP_SUB) ? alu_lv - alu_rv : alu_lv + alu_rv;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      q_tag.push_back(out_tag);
      q_val.push_back(out_value);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    q_tag.delete();
    q_val.delete();
    q_cyc.delete();
  endtask

  task automatic do_issue(input logic [3:0] op, input logic [31:0] vj, input logic qjb,
                          input logic [3:0] qj, input logic [31:0] vk, input logic qkb,
                          input logic [3:0] qk, input logic [3:0] dest);
    issue_valid = 1'b1; issue_op = op;
    issue_vj = vj; issue_qj_busy = qjb; issue_qj = qj;
    issue_vk = vk; issue_qk_busy = qkb; issue_qk = qk;
    issue_dest = dest;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ready: got %0b expected 0", alu_ready); end
    n_checks++; if (alu_lv !== 32'd0 || alu_rv !== 32'd0) begin n_fail++; $display("FAIL reset_alu_lv_rv: got %0d/%0d expected 0/0", alu_lv, alu_rv); end
    n_checks++; if (alu_op !== 4'd0) begin n_fail++; $display("FAIL reset_alu_op: got %0d expected 0", alu_op); end
    n_checks++; if (out_valid !== 1'b0 || out_tag !== 4'd0 || out_value !== 32'd0) begin n_fail++; $display("FAIL reset_out: got v=%0b t=%0d val=%0d expected 0/0/0", out_valid, out_tag, out_value); end
    n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_rs_full: got %0b expected 0", rs_full); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    do_issue(OP_ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL add_early_ready: got %0b expected 0", alu_ready); end
    @(negedge clk);
    n_checks++; if (alu_ready !== 1'b1 || alu_lv !== 32'd5 || alu_rv !== 32'd7 || alu_op !== OP_ADD) begin n_fail++; $display("FAIL add_dispatch: got r=%0b lv=%0d rv=%0d op=%0d expected 1/5/7/0", alu_ready, alu_lv, alu_rv, alu_op); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_tag !== 4'd3 || out_value !== 32'd12) begin n_fail++; $display("FAIL add_result: got v=%0b t=%0d val=%0d expected 1/3/12", out_valid, out_tag, out_value); end
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL add_ready_drop: got %0b expected 0", alu_ready); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_out_one_cycle: got %0b expected 0", out_valid); end
  endtask

  task automatic test_cdb_wakeup();
    do_issue(OP_SUB, 32'd0, 1'b1, 4'd9, 32'd1, 1'b0, 4'd0, 4'd4);
    repeat (2) @(negedge clk);
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL cdb_waiting: got %0b expected 0", alu_ready); end
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 32'd10;
    @(negedge clk);
    cdb_valid = 1'b0;
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL cdb_wake_latency: got %0b expected 0", alu_ready); end
    @(negedge clk);
    n_checks++; if (alu_ready !== 1'b1 || alu_lv !== 32'd10 || alu_rv !== 32'd1 || alu_op !== OP_SUB) begin n_fail++; $display("FAIL cdb_dispatch: got r=%0b lv=%0d rv=%0d op=%0d expected 1/10/1/1", alu_ready, alu_lv, alu_rv, alu_op); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_tag !== 4'd4 || out_value !== 32'd9) begin n_fail++; $display("FAIL cdb_result: got v=%0b t=%0d val=%0d expected 1/4/9", out_valid, out_tag, out_value); end
  endtask

  task automatic test_forward();
    clear_log();
    do_issue(OP_ADD, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd1);
    do_issue(OP_ADD, 32'd0, 1'b1, 4'd1, 32'd2, 1'b0, 4'd0, 4'd2);
    repeat (8) @(negedge clk);
    n_checks++; if (q_tag.size() != 2) begin n_fail++; $display("FAIL fwd_count: got %0d broadcasts expected 2", q_tag.size()); end
    if (q_tag.size() == 2) begin
      n_checks++; if (q_tag[0] !== 4'd1 || q_val[0] !== 32'd7) begin n_fail++; $display("FAIL fwd_first: got t=%0d val=%0d expected 1/7", q_tag[0], q_val[0]); end
      n_checks++; if (q_tag[1] !== 4'd2 || q_val[1] !== 32'd9) begin n_fail++; $display("FAIL fwd_second: got t=%0d val=%0d expected 2/9", q_tag[1], q_val[1]); end
      n_checks++; if (q_cyc[1] - q_cyc[0] != 3) begin n_fail++; $display("FAIL fwd_gap: got %0d cycles expected 3", q_cyc[1] - q_cyc[0]); end
    end
  endtask

  task automatic test_full();
    clear_log();
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL full_early_%0d: got %0b expected 0", i, rs_full); end
      do_issue(OP_ADD, 32'd0, 1'b1, 4'd15, 32'(100 + i), 1'b0, 4'd0, 4'(i));
    end
    n_checks++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %0b expected 1", rs_full); end
    $display("NOTE: dispatcher issues while rs_full=1 (tag 8); the op must be dropped");
    do_issue(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd8);
    n_checks++; if (rs_full !== 1'b1 || alu_ready !== 1'b0) begin n_fail++; $display("FAIL full_drop: got full=%0b ready=%0b expected 1/0", rs_full, alu_ready); end
    cdb_valid = 1'b1; cdb_tag = 4'd15; cdb_value = 32'd0;
    @(negedge clk);
    cdb_valid = 1'b0;
    n_checks++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_after_wake: got %0b expected 1", rs_full); end
    @(negedge clk);
    n_checks++; if (rs_full !== 1'b0 || alu_ready !== 1'b1 || alu_rv !== 32'd100) begin n_fail++; $display("FAIL full_first_dispatch: got full=%0b ready=%0b rv=%0d expected 0/1/100", rs_full, alu_ready, alu_rv); end
    repeat (12) @(negedge clk);
    n_checks++; if (q_tag.size() != 8) begin n_fail++; $display("FAIL full_count: got %0d broadcasts expected 8", q_tag.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < q_tag.size()) begin
        n_checks++;
        if (q_tag[i] !== 4'(i) || q_val[i] !== 32'(100 + i) || q_cyc[i] != q_cyc[0] + i) begin
          n_fail++;
          $display("FAIL full_order_%0d: got t=%0d val=%0d cyc=+%0d expected %0d/%0d/+%0d", i, q_tag[i], q_val[i], q_cyc[i] - q_cyc[0], i, 100 + i, i);
        end
      end
    end
  endtask

  task automatic test_stall();
    clear_log();
    alu_hold = 1'b1;
    do_issue(OP_ADD, 32'd20, 1'b0, 4'd0, 32'd22, 1'b0, 4'd0, 4'd5);
    do_issue(OP_SUB, 32'd50, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 4'd6);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (alu_ready !== 1'b1 || alu_lv !== 32'd20 || alu_rv !== 32'd22 || alu_op !== OP_ADD || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got r=%0b lv=%0d rv=%0d op=%0d ov=%0b expected 1/20/22/0/0", k, alu_ready, alu_lv, alu_rv, alu_op, out_valid);
      end
      @(negedge clk);
    end
    alu_hold = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (q_tag.size() != 2) begin n_fail++; $display("FAIL stall_count: got %0d broadcasts expected 2", q_tag.size()); end
    if (q_tag.size() == 2) begin
      n_checks++; if (q_tag[0] !== 4'd5 || q_val[0] !== 32'd42) begin n_fail++; $display("FAIL stall_first: got t=%0d val=%0d expected 5/42", q_tag[0], q_val[0]); end
      n_checks++; if (q_tag[1] !== 4'd6 || q_val[1] !== 32'd41 || q_cyc[1] != q_cyc[0] + 1) begin n_fail++; $display("FAIL stall_resume: got t=%0d val=%0d gap=%0d expected 6/41/1", q_tag[1], q_val[1], q_cyc[1] - q_cyc[0]); end
    end
  endtask

  task automatic test_flush();
    alu_hold = 1'b1;
    do_issue(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd8);
    for (int i = 0; i < 4; i++) do_issue(OP_ADD, 32'd0, 1'b1, 4'd13, 32'(i), 1'b0, 4'd0, 4'(9 + i));
    n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL flush_pre_inflight: got %0b expected 1", alu_ready); end
    flush = 1'b1;
    issue_valid = 1'b1; issue_op = OP_ADD; issue_vj = 32'd2; issue_qj_busy = 1'b0;
    issue_vk = 32'd2; issue_qk_busy = 1'b0; issue_dest = 4'd14;
    cdb_valid = 1'b1; cdb_tag = 4'd13; cdb_value = 32'd5;
    @(negedge clk);
    flush = 1'b0; issue_valid = 1'b0; cdb_valid = 1'b0;
    n_checks++; if (alu_ready !== 1'b0 || out_valid !== 1'b0 || rs_full !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got r=%0b ov=%0b full=%0b expected 0/0/0", alu_ready, out_valid, rs_full); end
    alu_hold = 1'b0;
    clear_log();
    for (int i = 0; i < 7; i++) do_issue(OP_ADD, 32'd0, 1'b1, 4'd12, 32'(i), 1'b0, 4'd0, 4'(i));
    n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL flush_capacity: got full=%0b expected 0", rs_full); end
    cdb_valid = 1'b1; cdb_tag = 4'd12; cdb_value = 32'd0;
    @(negedge clk);
    cdb_valid = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++; if (q_tag.size() != 7) begin n_fail++; $display("FAIL flush_leftover: got %0d broadcasts expected 7", q_tag.size()); end
    if (q_tag.size() == 7) begin
      n_checks++; if (q_tag[0] !== 4'd0 || q_val[6] !== 32'd6) begin n_fail++; $display("FAIL flush_post_ops: got t0=%0d val6=%0d expected 0/6", q_tag[0], q_val[6]); end
    end
  endtask

  task automatic test_rdy_freeze();
    clear_log();
    do_issue(OP_ADD, 32'd10, 1'b0, 4'd0, 32'd20, 1'b0, 4'd0, 4'd1);
    do_issue(OP_SUB, 32'd0, 1'b1, 4'd7, 32'd5, 1'b0, 4'd0, 4'd2);
    rdy = 1'b0;
    issue_valid = 1'b1; issue_op = OP_ADD; issue_vj = 32'd3; issue_qj_busy = 1'b0;
    issue_vk = 32'd3; issue_qk_busy = 1'b0; issue_dest = 4'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (alu_ready !== 1'b1 || alu_lv !== 32'd10 || alu_rv !== 32'd20 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rdy_freeze_%0d: got r=%0b lv=%0d rv=%0d ov=%0b expected 1/10/20/0", k, alu_ready, alu_lv, alu_rv, out_valid);
      end
    end
    issue_valid = 1'b0;
    rdy = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 32'd100;
    @(negedge clk);
    cdb_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (q_tag.size() != 2) begin n_fail++; $display("FAIL rdy_count: got %0d broadcasts expected 2", q_tag.size()); end
    if (q_tag.size() == 2) begin
      n_checks++; if (q_tag[0] !== 4'd1 || q_val[0] !== 32'd30) begin n_fail++; $display("FAIL rdy_first: got t=%0d val=%0d expected 1/30", q_tag[0], q_val[0]); end
      n_checks++; if (q_tag[1] !== 4'd2 || q_val[1] !== 32'd95) begin n_fail++; $display("FAIL rdy_second: got t=%0d val=%0d expected 2/95", q_tag[1], q_val[1]); end
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; alu_hold = 1'b0;
    issue_valid = 1'b0; issue_op = '0; issue_vj = '0; issue_qj_busy = 1'b0; issue_qj = '0;
    issue_vk = '0; issue_qk_busy = 1'b0; issue_qk = '0; issue_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_cdb_wakeup();
    test_forward();
    test_full();
    test_stall();
    test_flush();
    test_rdy_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
